// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: groups the ID/EXMEM/WB hazard inputs and pipeline-control outputs of pipeline_hazard_ctrl.
// Latency: wires only; no storage.
// Backpressure: none here; pcWrite/ifidWrite act as the front-end hold. HAZARD_PERF_EN adds perf counters.
interface pipeline_hazard_ctrl_if;
   // ID stage source operands
   logic [5:0]  rs1_ID;
   logic [5:0]  rs2_ID;
   logic        useRs1_ID;
   logic        useRs2_ID;
   // pending writes further down the pipe
   logic        regWrite_EX;
   logic [5:0]  rd_EX;
   logic        regWrite_WB;
   logic [5:0]  rd_WB;
   logic        redirect_WB;
   // pipeline control
   logic        pcWrite;
   logic        ifidWrite;
   logic        ifidFlush;
   logic        idexFlush;
   logic        stall;
   logic [1:0]  state;
   logic        hazardErr;
`ifdef HAZARD_PERF_EN
   logic [31:0] stallCount;
   logic [31:0] flushCount;
`endif

   // pipeline side: supplies register indices, consumes control
   modport master (
      output rs1_ID, rs2_ID, useRs1_ID, useRs2_ID,
             regWrite_EX, rd_EX, regWrite_WB, rd_WB, redirect_WB,
      input  pcWrite, ifidWrite, ifidFlush, idexFlush, stall, state, hazardErr
`ifdef HAZARD_PERF_EN
      , input stallCount, flushCount
`endif
   );

   // controller side
   modport slave (
      input  rs1_ID, rs2_ID, useRs1_ID, useRs2_ID,
             regWrite_EX, rd_EX, regWrite_WB, rd_WB, redirect_WB,
      output pcWrite, ifidWrite, ifidFlush, idexFlush, stall, state, hazardErr
`ifdef HAZARD_PERF_EN
      , output stallCount, flushCount
`endif
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: IF/ID/EXMEM/WB sequencer: startup gating, RAW stall, redirect squash (HAZARD_PERF_EN adds perf counters).
// Latency: control outputs are Mealy, same cycle as the inputs; state and counters update at the clock edge.
// Backpressure: a RAW hazard holds PC and IF_ID and injects bubbles into ID_EXMEM; redirect beats hazard.
module pipeline_hazard_ctrl #(
   parameter int unsigned STARTUP_CYCLES   = 4,
   parameter int unsigned REDIRECT_BUBBLES = 1,
   parameter int unsigned R0_HARDWIRED     = 1,
   parameter int unsigned MAX_STALL        = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   pipeline_hazard_ctrl_if.slave  hif
);

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   // HOLD leaves on the edge where the edge count reaches STARTUP_CYCLES.
   localparam logic [15:0] START_LAST  = (STARTUP_CYCLES == 0) ? 16'd0 : 16'(STARTUP_CYCLES - 1);
   localparam logic [15:0] BUB_LOAD    = 16'(REDIRECT_BUBBLES);
   // Stall run length that flags an error; the counter saturates here.
   localparam logic [15:0] STALL_LIMIT = 16'(MAX_STALL + 1);
   // With no extra bubbles a redirect returns straight to RUN.
   localparam state_t      REDIR_NEXT  = (REDIRECT_BUBBLES == 0) ? ST_RUN : ST_FLUSH;
   localparam bit          R0_ZERO     = (R0_HARDWIRED != 0);

   state_t      state_q, state_d;
   logic [15:0] start_q, start_d;
   logic [15:0] bub_q, bub_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        err_q, err_d;

   logic        rs1_chk, rs2_chk, rs1_hit, rs2_hit, hazard;
   logic        pc_write, ifid_write, ifid_flush, idex_flush, stall;
   logic        err_set;

   // An operand only matters if the instruction reads it and it is not the hardwired zero register.
   assign rs1_chk = hif.useRs1_ID && !(R0_ZERO && (hif.rs1_ID == 6'd0));
   assign rs2_chk = hif.useRs2_ID && !(R0_ZERO && (hif.rs2_ID == 6'd0));

   // The register file writes at the edge, so a WB producer is still a hazard this cycle.
   assign rs1_hit = (hif.regWrite_EX && (hif.rs1_ID == hif.rd_EX)) ||
                    (hif.regWrite_WB && (hif.rs1_ID == hif.rd_WB));
   assign rs2_hit = (hif.regWrite_EX && (hif.rs2_ID == hif.rd_EX)) ||
                    (hif.regWrite_WB && (hif.rs2_ID == hif.rd_WB));
   assign hazard  = (rs1_chk && rs1_hit) || (rs2_chk && rs2_hit);

   // Next-state and Mealy control outputs; redirect outranks hazard in every active state.
   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      bub_d      = bub_q;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      stall      = 1'b0;
      case (state_q)
         ST_RUN, ST_STALL: begin
            if (hif.redirect_WB) begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               bub_d      = BUB_LOAD;
               state_d    = REDIR_NEXT;
            end else if (hazard) begin
               idex_flush = 1'b1;
               stall      = 1'b1;
               state_d    = ST_STALL;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               state_d    = ST_RUN;
            end
         end
         ST_FLUSH: begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            if (hif.redirect_WB) begin
               // a fresh redirect restarts the squash window
               idex_flush = 1'b1;
               bub_d      = BUB_LOAD;
               state_d    = REDIR_NEXT;
            end else if (bub_q <= 16'd1) begin
               // IF_ID holds a NOP here, so no hazard check is needed
               bub_d   = 16'd0;
               state_d = ST_RUN;
            end else begin
               bub_d = bub_q - 16'd1;
            end
         end
         default: begin
            // ST_HOLD: everything frozen, IF_ID/ID_EXMEM forced empty, redirects ignored
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (start_q >= START_LAST) begin
               start_d = 16'd0;
               state_d = ST_RUN;
            end else begin
               start_d = start_q + 16'd1;
            end
         end
      endcase
   end

   // Consecutive-stall run length; any non-stall cycle ends the run.
   always_comb begin
      stall_cnt_d = 16'd0;
      if (stall) begin
         stall_cnt_d = (stall_cnt_q == STALL_LIMIT) ? stall_cnt_q : stall_cnt_q + 16'd1;
      end
   end

   // The error shows in the cycle the run reaches its limit and then sticks until reset.
   assign err_set = stall && (stall_cnt_d == STALL_LIMIT);
   assign err_d   = err_q || err_set;

   // State, counters and sticky error.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_HOLD;
         start_q     <= 16'd0;
         bub_q       <= 16'd0;
         stall_cnt_q <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         bub_q       <= bub_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   assign hif.pcWrite   = pc_write;
   assign hif.ifidWrite = ifid_write;
   assign hif.ifidFlush = ifid_flush;
   assign hif.idexFlush = idex_flush;
   assign hif.stall     = stall;
   assign hif.state     = state_q;
   assign hif.hazardErr = err_d;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] flush_count_q, flush_count_d;
   logic        redir_acc;

   // A redirect counts only once the pipeline is out of HOLD.
   assign redir_acc = hif.redirect_WB && (state_q != ST_HOLD);

   // Saturating event counters.
   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
      if (redir_acc && (flush_count_q != 32'hFFFF_FFFF)) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count_q <= 32'd0;
         flush_count_q <= 32'd0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign hif.stallCount = stall_count_q;
   assign hif.flushCount = flush_count_q;
`endif

endmodule
